// File: rtl/cpu_bus_arb_pkg.sv
// Shared definitions for the CPU/debug bus arbiter: arbiter state encoding,
// bus widths and the default drain timeout.
package cpu_bus_arb_pkg;

    localparam int ADDR_W                = 16;
    localparam int DATA_W                = 8;
    localparam int DRAIN_CNT_W           = 8;
    localparam int DRAIN_TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_CPU      = 3'd0,
        S_DRAIN    = 3'd1,
        S_TURN_IN  = 3'd2,
        S_DBG      = 3'd3,
        S_TURN_OUT = 3'd4
    } arb_state_t;

    function automatic logic is_turnaround(arb_state_t s);
        return (s == S_TURN_IN) || (s == S_TURN_OUT);
    endfunction

endpackage

// File: rtl/cpu_bus_arb_drain_timer.sv
// Saturating drain counter; flags the drain cycle on which the arbiter must
// stop waiting for an instruction boundary and take the bus by force.
module arb_drain_timer
    import cpu_bus_arb_pkg::*;
#(
    parameter int TIMEOUT = DRAIN_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [DRAIN_CNT_W-1:0] LAST = DRAIN_CNT_W'(TIMEOUT - 1);
    localparam logic [DRAIN_CNT_W-1:0] MAX  = '1;

    logic [DRAIN_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of completed drain cycles, so the cycle with
    // count == TIMEOUT-1 is the TIMEOUT-th cycle spent draining
    assign timeout = enable && (count >= LAST);

endmodule

// File: rtl/cpu_bus_arb.sv
// Arbitrates the shared memory-controller port between the CPU core and the
// debug block, handing the bus over on instruction boundaries with turnarounds.
module cpu_bus_arb
    import cpu_bus_arb_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic              cpu_r_nw,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_sync,
    output logic              cpu_rdy,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_a,
    input  logic              dbg_r_nw,
    input  logic [DATA_W-1:0] dbg_dout,
    output logic              dbg_gnt,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_r_nw,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] rdata,
    output logic              arb_err
);

    arb_state_t state;
    logic       drain_timeout;

    arb_drain_timer #(
        .TIMEOUT(DRAIN_TIMEOUT)
    ) u_drain_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != S_DRAIN),
        .enable (state == S_DRAIN),
        .timeout(drain_timeout)
    );

    // Outputs are updated alongside the state so they always describe the
    // state being entered; a pending dbg_req in S_TURN_OUT waits for S_CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CPU;
            cpu_rdy <= 1'b1;
            dbg_gnt <= 1'b0;
            arb_err <= 1'b0;
        end else begin
            case (state)
                S_CPU: begin
                    if (dbg_req && cpu_sync) begin
                        state   <= S_TURN_IN;
                        cpu_rdy <= 1'b0;
                    end else if (dbg_req) begin
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!dbg_req) begin
                        state   <= S_CPU;
                    end else if (cpu_sync) begin
                        state   <= S_TURN_IN;
                        cpu_rdy <= 1'b0;
                    end else if (drain_timeout) begin
                        state   <= S_TURN_IN;
                        cpu_rdy <= 1'b0;
                        arb_err <= 1'b1;
                    end
                end
                S_TURN_IN: begin
                    state   <= S_DBG;
                    dbg_gnt <= 1'b1;
                end
                S_DBG: begin
                    if (!dbg_req) begin
                        state   <= S_TURN_OUT;
                        dbg_gnt <= 1'b0;
                    end
                end
                S_TURN_OUT: begin
                    state   <= S_CPU;
                    cpu_rdy <= 1'b1;
                end
                default: begin
                    state   <= S_CPU;
                    cpu_rdy <= 1'b1;
                    dbg_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Turnaround cycles keep the CPU address on the bus but never write
    always_comb begin
        mem_a    = cpu_a;
        mem_r_nw = cpu_r_nw;
        mem_dout = cpu_dout;
        if (state == S_DBG) begin
            mem_a    = dbg_a;
            mem_r_nw = dbg_r_nw;
            mem_dout = dbg_dout;
        end else if (is_turnaround(state)) begin
            mem_r_nw = 1'b1;
        end
    end

    assign rdata = mem_din;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Scoreboard bench for cpu_bus_arb: each stimulus cycle queues the outputs
// expected after the next clock edge, and a monitor compares them.
module tb_cpu_bus_arb;

    typedef struct packed {
        logic        rdy;
        logic        gnt;
        logic        err;
        logic [15:0] a;
        logic        r_nw;
        logic [7:0]  dout;
        logic        chk_rdata;
        logic [7:0]  rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_a = '0;
    logic        cpu_r_nw = 1'b1;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_sync = 1'b0;
    logic        cpu_rdy;
    logic        dbg_req = 1'b0;
    logic [15:0] dbg_a = '0;
    logic        dbg_r_nw = 1'b1;
    logic [7:0]  dbg_dout = '0;
    logic        dbg_gnt;
    logic [15:0] mem_a;
    logic        mem_r_nw;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;
    logic [7:0]  rdata;
    logic        arb_err;

    logic [7:0]  mem [0:1023];
    exp_t        exp_q[$];
    string       tag_q[$];
    exp_t        mon_e;
    string       mon_t;
    int          checks = 0;
    int          errors = 0;

    cpu_bus_arb #(.DRAIN_TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu_a   (cpu_a),
        .cpu_r_nw(cpu_r_nw),
        .cpu_dout(cpu_dout),
        .cpu_sync(cpu_sync),
        .cpu_rdy (cpu_rdy),
        .dbg_req (dbg_req),
        .dbg_a   (dbg_a),
        .dbg_r_nw(dbg_r_nw),
        .dbg_dout(dbg_dout),
        .dbg_gnt (dbg_gnt),
        .mem_a   (mem_a),
        .mem_r_nw(mem_r_nw),
        .mem_dout(mem_dout),
        .mem_din (mem_din),
        .rdata   (rdata),
        .arb_err (arb_err)
    );

    always #10 clk = ~clk;

    // Memory controller with one cycle of read latency
    always @(posedge clk) begin
        if (!mem_r_nw) mem[mem_a[9:0]] <= mem_dout;
        mem_din <= mem[mem_a[9:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One cycle of stimulus; the expected bus owner follows from rdy/gnt
    task automatic applyStimulus(input string tag, input logic req, input logic sync,
                                 input logic dbg_wr, input logic [15:0] da, input logic [7:0] dd,
                                 input logic e_rdy, input logic e_gnt, input logic e_err,
                                 input logic chk_rd, input logic [7:0] e_rd);
        exp_t        e;
        logic [15:0] r;
        @(negedge clk);
        r        = 16'($urandom);
        cpu_a    = r & 16'hFDFF;
        cpu_r_nw = 1'($urandom);
        cpu_dout = 8'($urandom);
        cpu_sync = sync;
        dbg_req  = req;
        dbg_a    = da;
        dbg_r_nw = !dbg_wr;
        dbg_dout = dd;
        e.rdy       = e_rdy;
        e.gnt       = e_gnt;
        e.err       = e_err;
        e.chk_rdata = chk_rd;
        e.rdata     = e_rd;
        if (e_gnt) begin
            e.a = da; e.r_nw = !dbg_wr; e.dout = dd;
        end else if (e_rdy) begin
            e.a = cpu_a; e.r_nw = cpu_r_nw; e.dout = cpu_dout;
        end else begin
            e.a = cpu_a; e.r_nw = 1'b1; e.dout = cpu_dout;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step(input string tag, input logic req, input logic sync,
                        input logic e_rdy, input logic e_gnt, input logic e_err);
        applyStimulus(tag, req, sync, 1'b0, 16'($urandom), 8'($urandom),
                      e_rdy, e_gnt, e_err, 1'b0, 8'h00);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                checkOutput({mon_t, ".cpu_rdy"}, 32'(cpu_rdy), 32'(mon_e.rdy));
                checkOutput({mon_t, ".dbg_gnt"}, 32'(dbg_gnt), 32'(mon_e.gnt));
                checkOutput({mon_t, ".arb_err"}, 32'(arb_err), 32'(mon_e.err));
                checkOutput({mon_t, ".mem_a"}, 32'(mem_a), 32'(mon_e.a));
                checkOutput({mon_t, ".mem_r_nw"}, 32'(mem_r_nw), 32'(mon_e.r_nw));
                checkOutput({mon_t, ".mem_dout"}, 32'(mem_dout), 32'(mon_e.dout));
                if (mon_e.chk_rdata)
                    checkOutput({mon_t, ".rdata"}, 32'(rdata), 32'(mon_e.rdata));
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        #5 rst = 1'b1;
        #3;
        checkOutput("reset.cpu_rdy", 32'(cpu_rdy), 32'd1);
        checkOutput("reset.dbg_gnt", 32'(dbg_gnt), 32'd0);
        checkOutput("reset.arb_err", 32'(arb_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Request on an instruction boundary; request in TURN_OUT is ignored
        step("a_req",  1, 1, 0, 0, 0);
        step("a_turn", 1, 0, 0, 1, 0);
        step("a_hold", 1, 0, 0, 1, 0);
        step("a_rel",  0, 0, 0, 0, 0);
        step("a_out",  1, 1, 1, 0, 0);
        step("a_idle", 0, 0, 1, 0, 0);

        // Drain for five cycles, then sync; debug write then read back
        for (int i = 0; i < 5; i++) step($sformatf("b_drain%0d", i), 1, 0, 1, 0, 0);
        step("b_sync", 1, 1, 0, 0, 0);
        step("b_gnt",  1, 0, 0, 1, 0);
        applyStimulus("b_wr", 1, 0, 1, 16'h0300, 8'hA5, 0, 1, 0, 0, 8'h00);
        applyStimulus("b_rd", 1, 0, 0, 16'h0300, 8'h00, 0, 1, 0, 1, 8'hA5);
        step("b_rel",  0, 0, 0, 0, 0);
        step("b_back", 0, 0, 1, 0, 0);

        // Request withdrawn while draining
        step("c_enter", 1, 0, 1, 0, 0);
        step("c_drain", 1, 0, 1, 0, 0);
        step("c_abort", 0, 0, 1, 0, 0);
        step("c_idle",  0, 0, 1, 0, 0);

        // Drain timeout: 16 drain cycles then forced takeover
        step("d_enter", 1, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) step($sformatf("d_drain%0d", i + 2), 1, 0, 1, 0, 0);
        step("d_timeout", 1, 0, 0, 0, 1);
        step("d_gnt",     1, 0, 0, 1, 1);
        step("d_rel",     0, 0, 0, 0, 1);
        step("d_back",    0, 0, 1, 0, 1);
        step("d_sticky",  0, 0, 1, 0, 1);

        // Asynchronous reset in the middle of a debug tenure
        step("e_req", 1, 1, 0, 0, 1);
        step("e_gnt", 1, 0, 0, 1, 1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("e_rst.dbg_gnt", 32'(dbg_gnt), 32'd0);
        checkOutput("e_rst.cpu_rdy", 32'(cpu_rdy), 32'd1);
        checkOutput("e_rst.arb_err", 32'(arb_err), 32'd0);
        checkOutput("e_rst.mem_a", 32'(mem_a), 32'(cpu_a));
        checkOutput("e_rst.mem_r_nw", 32'(mem_r_nw), 32'(cpu_r_nw));
        @(negedge clk);
        rst = 1'b0;
        dbg_req = 1'b0;

        // Normal operation after reset; TURN_IN and minimum one-cycle tenure
        step("f_idle", 0, 0, 1, 0, 0);
        step("f_req",  1, 1, 0, 0, 0);
        step("f_turn", 0, 0, 0, 1, 0);
        step("f_out",  0, 0, 0, 0, 0);
        step("f_cpu",  0, 0, 1, 0, 0);

        @(posedge clk);
        #3;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arb.md
CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 16, max cycles in S_DRAIN waiting for cpu_sync before forced takeover (range 2..255).
REQ-002 clk  in  1  system clock (50 MHz); the block has one clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_a  in  16  CPU core address.
REQ-005 cpu_r_nw  in  1  CPU core read(1)/write(0).
REQ-006 cpu_dout  in  8  CPU core write data.
REQ-007 cpu_sync  in  1  high on the CPU opcode-fetch cycle (instruction boundary).
REQ-008 cpu_rdy  out  1  CPU stall; 0 freezes the core.
REQ-009 dbg_req  in  1  debug block requests bus ownership; held for the whole tenure.
REQ-010 dbg_a  in  16  debug address.
REQ-011 dbg_r_nw  in  1  debug read(1)/write(0).
REQ-012 dbg_dout  in  8  debug write data.
REQ-013 dbg_gnt  out  1  debug owns the bus this cycle.
REQ-014 mem_a  out  16  shared memory-controller address.
REQ-015 mem_r_nw  out  1  shared memory-controller R/!W.
REQ-016 mem_dout  out  8  shared memory-controller write data.
REQ-017 mem_din  in  8  memory-controller read data.
REQ-018 rdata  out  8  read data to both requesters; combinational copy of mem_din.
REQ-019 arb_err  out  1  sticky flag: drain timeout occurred.

Function
REQ-020 States: S_CPU, S_DRAIN, S_TURN_IN, S_DBG, S_TURN_OUT; state, cpu_rdy, dbg_gnt, and arb_err are registered.
REQ-021 S_CPU: dbg_req=1 and cpu_sync=1 -> S_TURN_IN; dbg_req=1 and cpu_sync=0 -> S_DRAIN; otherwise stay.
REQ-022 S_DRAIN: dbg_req=0 -> S_CPU (abort, no error); cpu_sync=1 -> S_TURN_IN; drain counter reaching DRAIN_TIMEOUT -> S_TURN_IN and set arb_err.
REQ-023 Drain counter: 8 bits, cleared on every entry to S_DRAIN, increments once per S_DRAIN cycle, saturates and never wraps.
REQ-024 S_TURN_IN lasts exactly one cycle -> S_DBG.
REQ-025 S_DBG: stay while dbg_req=1; dbg_req=0 -> S_TURN_OUT; minimum tenure is one cycle.
REQ-026 S_TURN_OUT lasts exactly one cycle -> S_CPU; a dbg_req seen in this state is not serviced until S_CPU.
REQ-027 cpu_rdy=0 in S_TURN_IN, S_DBG, and S_TURN_OUT; cpu_rdy=1 in S_CPU and S_DRAIN.
REQ-028 dbg_gnt=1 only in S_DBG.
REQ-029 In S_CPU and S_DRAIN, mem_a/mem_r_nw/mem_dout = cpu_a/cpu_r_nw/cpu_dout.
REQ-030 In S_DBG, mem_a/mem_r_nw/mem_dout = dbg_a/dbg_r_nw/dbg_dout.
REQ-031 In turnaround states: mem_a=cpu_a, mem_dout=cpu_dout, and mem_r_nw forced to 1 (no write is ever issued in turnaround).
REQ-032 The debug read data is valid on rdata one cycle after the corresponding dbg_a is presented while dbg_gnt=1.
REQ-033 The CPU core never sees a write suppressed while cpu_rdy=1.
REQ-034 arb_err, once set, holds until reset.

Reset
REQ-035 Asserting rst immediately forces: state=S_CPU, drain counter=0, cpu_rdy=1, dbg_gnt=0, arb_err=0.
REQ-036 Reset mid-tenure (S_DBG) drops dbg_gnt asynchronously and returns the bus to the CPU without a turnaround cycle.
REQ-037 On the first clk edge after rst deasserts, the block evaluates transitions normally from S_CPU.

Structure
REQ-038 A shared package holds: the state encoding (3 bits, S_CPU=0 through S_TURN_OUT=4), the bus widths (address 16, data 8), and the DRAIN_TIMEOUT default.
REQ-039 Sub-module arb_drain_timer (saturating counter with clear/enable and a timeout pulse) is natural; all other logic stays flat.
REQ-040 The debug block connects via dbg_*; the CPU core connects via cpu_* and cpu_rdy; the memory controller connects via mem_*.

Verification
REQ-041 dbg_req=1 together with cpu_sync=1 in S_CPU -> cpu_rdy=0 next cycle, dbg_gnt=1 two cycles later, arb_err=0.
REQ-042 dbg_req=1 with cpu_sync low for 5 cycles, then high -> stays in S_DRAIN with cpu_rdy=1 for those 5 cycles, then TURN_IN, then dbg_gnt=1.
REQ-043 dbg_req=1 with cpu_sync never asserted, DRAIN_TIMEOUT=16 -> dbg_gnt=1 after 16 drain cycles + 1 turnaround; arb_err=1 and sticky after dbg_req drops.
REQ-044 In S_DBG, write dbg_a=16'h0300, dbg_dout=8'hA5 then read 16'h0300 -> mem_r_nw=0 for one cycle; rdata=8'hA5 on the cycle after the read address.
REQ-045 dbg_req dropped while in S_DRAIN -> S_CPU next cycle, dbg_gnt never asserted, cpu_rdy stays 1.
REQ-046 rst pulsed mid-S_DBG -> dbg_gnt=0 and cpu_rdy=1 immediately (asynchronously); mem_a follows cpu_a; arb_err=0.
